// File: rtl/serial_readout_sequencer_pkg.sv
// Shared readout definitions: FSM state encoding and default channel-array geometry.
package psec5_readout_pkg;

  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_WORD_BITS = 50;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

endpackage

// File: rtl/serial_readout_sequencer_enc.sv
// Lowest-set-bit priority encoder; valid is low when no bit is set.
module lowest_set_bit_enc #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] vec,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (vec[i] && !valid) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_readout_sequencer.sv
// Sequences per-channel serial readout onto one line: index header, word shift, idle gap,
// in ascending channel order over a mask captured at start.
module serial_readout_sequencer
  import psec5_readout_pkg::*;
#(
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int WORD_BITS  = DEF_WORD_BITS,
  parameter  int GAP_CYCLES = 1,
  localparam int CH_IDX_W   = $clog2(NUM_CH)
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                readout_req,
  input  logic                abort,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [NUM_CH-1:0]   raw_serial_out,
  input  logic                wr_serial_out,
  output logic [NUM_CH-1:0]   load_cnt_ser,
  output logic                serial_out,
  output logic                busy,
  output logic                done,
  output logic [CH_IDX_W-1:0] cur_ch
);

  localparam int BIT_W = $clog2(WORD_BITS + 1);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_HDR = BIT_W'(CH_IDX_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [NUM_CH-1:0]   remainder;
  logic [NUM_CH-1:0]   enc_in;
  logic [CH_IDX_W-1:0] enc_idx;
  logic                enc_valid;
  logic [BIT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CH_IDX_W-1:0] hdr_sr;

  assign remainder = mask_q & ~(NUM_CH'(1) << cur_ch);

  // One encoder serves all three decision points: start, end of word, end of gap.
  always_comb begin
    case (state)
      S_IDLE:  enc_in = ch_mask;
      S_SHIFT: enc_in = remainder;
      default: enc_in = mask_q;
    endcase
  end

  lowest_set_bit_enc #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_IDX_W)
  ) u_enc (
    .vec   (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    case (state)
      S_IDLE:   serial_out = wr_serial_out;
      S_HEADER: serial_out = hdr_sr[CH_IDX_W-1];
      S_SHIFT:  serial_out = raw_serial_out[cur_ch];
      default:  serial_out = 1'b0;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      mask_q       <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      hdr_sr       <= '0;
      cur_ch       <= '0;
      load_cnt_ser <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        state        <= S_IDLE;
        mask_q       <= '0;
        bit_cnt      <= '0;
        gap_cnt      <= '0;
        cur_ch       <= '0;
        load_cnt_ser <= '0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (readout_req) begin
              mask_q  <= ch_mask;
              bit_cnt <= '0;
              busy    <= 1'b1;
              if (enc_valid) begin
                state  <= S_HEADER;
                cur_ch <= enc_idx;
                hdr_sr <= enc_idx;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_HEADER: begin
            hdr_sr <= hdr_sr << 1;
            if (bit_cnt == LAST_HDR) begin
              state        <= S_SHIFT;
              bit_cnt      <= '0;
              load_cnt_ser <= NUM_CH'(1) << cur_ch;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_SHIFT: begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt      <= '0;
              load_cnt_ser <= '0;
              mask_q       <= remainder;
              if (!enc_valid) begin
                state  <= S_DONE;
                done   <= 1'b1;
                cur_ch <= '0;
              end else if (GAP_CYCLES == 0) begin
                state  <= S_HEADER;
                cur_ch <= enc_idx;
                hdr_sr <= enc_idx;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
                cur_ch  <= '0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt == LAST_GAP) begin
              state  <= S_HEADER;
              cur_ch <= enc_idx;
              hdr_sr <= enc_idx;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
